data_memory_be: RTL and testbench
=================================

DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; the byte address space is 4*DEPTH_WORDS.
REQ-002 Parameter ADDR_W, default 32, width of req_addr.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request can be accepted; a transfer occurs when req_valid and req_ready are both 1 at a rising edge.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I access size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  one-cycle response pulse.
REQ-012 rsp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  the access was rejected; valid only while rsp_valid is 1.

Function
REQ-014 Every accepted request produces exactly one rsp_valid pulse; responses are in order; there is no response backpressure.
REQ-015 The FSM has states IDLE and SPLIT.
REQ-016 req_ready is 1 in IDLE and 0 in SPLIT.
REQ-017 Single-phase latency: rsp_valid is asserted in the cycle after acceptance; back-to-back requests are accepted every cycle.
REQ-018 The word index is req_addr[ADDR_W-1:2] and the byte lane is req_addr[1:0].
REQ-019 Stores write only the addressed byte lanes at the acceptance edge; all other bytes are unchanged.
REQ-020 Loads sample memory at the acceptance edge:
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW returns the word unmodified.
REQ-021 A store followed by a load to the same address in the next cycle returns the new data.
REQ-022 An error response (rsp_err=1, rsp_rdata=0, no write) is produced for any of the following:
- funct3 not in {000,001,010,100,101};
- a store with funct3 100 or 101;
- any touched word index >= DEPTH_WORDS.
REQ-023 Alignment is defined as follows:
- A halfword is aligned when addr[0]=0.
- A word is aligned when addr[1:0]=00.
- An access crosses a word boundary when lane + size > 4.
REQ-024 A misaligned access that does not cross a word boundary (a halfword at lane 1) is serviced in a single phase when DMEM_MISALIGN_EN is defined, and gets an error response otherwise.
REQ-025 Error responses follow the single-phase latency and assert no write enables.

Reset
REQ-026 When rst=1 at a rising edge, the following hold after that edge:
- the FSM is in IDLE;
- rsp_valid=0, rsp_err=0, rsp_rdata=0;
- req_ready=1 in the cycle after the edge.
REQ-027 Requests presented while rst=1 are not accepted and produce no write.
REQ-028 Memory contents are not cleared by rst; all words are 0 at simulation start.
REQ-029 A reset in SPLIT abandons the second phase and produces no response; first-phase store bytes already written remain written.

Configuration
REQ-030 Macro DMEM_MISALIGN_EN selects misaligned-access handling.
- With the macro defined: a boundary-crossing access is split.
  - Phase 1 at the acceptance edge covers the low word, and the FSM enters SPLIT.
  - Phase 2 at the next edge covers word index+1, and the FSM returns to IDLE.
  - rsp_valid is asserted 2 cycles after acceptance, with the bytes merged in little-endian order.
  - If either word is out of range, no bytes are written and the response is an error after the same 2-cycle latency.
- Without the macro: every misaligned access gets a single-phase error response, and SPLIT is unreachable (req_ready stays 1).

Verification
REQ-031 SW addr 0x10 data 0xA1B2C3D4, then LW 0x10 -> rsp_rdata=0xA1B2C3D4, rsp_err=0, rsp_valid one cycle after each request.
REQ-032 SB addr 0x11 data 0x000000FF over word 0x00000000, then LB 0x11 and LBU 0x11 -> LB gives 0xFFFFFFFF, LBU gives 0x000000FF, LW 0x10 gives 0x0000FF00.
REQ-033 LW addr 0x4*DEPTH_WORDS, then funct3=011 load, then SH with funct3=101 -> three responses each with rsp_err=1 and rsp_rdata=0; memory unchanged.
REQ-034 Words 0x20=0x44332211 and 0x24=0x88776655, LW addr 0x23:
- with DMEM_MISALIGN_EN: req_ready=0 for one cycle, rsp_valid 2 cycles later, rsp_rdata=0x77665544;
- without the macro: rsp_err=1 after one cycle.
REQ-035 DMEM_MISALIGN_EN, SW addr 0x26 data 0xDEADBEEF with rst asserted on the cycle after acceptance:
- no response;
- word 0x24 upper half = 0xBEEF;
- word 0x28 unchanged;
- req_ready=1 after reset.
REQ-036 Eight back-to-back alternating SW/LW at consecutive words -> eight responses on eight consecutive cycles, req_ready held at 1, each load returning the data just stored.

Source files
------------

// File: rtl/data_memory_be.sv
// Byte-enabled RV32I data memory with in-order single-pulse responses; optional DMEM_MISALIGN_EN splits word-crossing accesses.
// Latency: response 1 cycle after acceptance, 2 cycles for a split access.
// Backpressure: req_ready drops only during the second phase of a split; responses cannot be stalled.
module data_memory_be #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

`ifdef DMEM_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int XW = ADDR_W - 1;
    localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH_WORDS);

    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, acc_wr, ph2_wr;
    logic [1:0]    lane;
    logic [3:0]    size;
    logic [7:0]    mask, be8;
    logic [63:0]   wd64;
    logic [XW-1:0] widx, widx1;
    logic [IW-1:0] idx, idx1;
    logic          fmt_ok, misaligned, crosses, range_err, misal_err, req_err, split_go;

    // second-phase context held while in SPLIT
    logic [IW-1:0] sp_idx;
    logic [3:0]    sp_be;
    logic [31:0]   sp_wd, sp_lo;
    logic          sp_we, sp_err;
    logic [1:0]    sp_lane;
    logic [2:0]    sp_f3;

    function automatic logic [31:0] extract(input logic [63:0] win, input logic [1:0] ln,
                                            input logic [2:0] f3);
        logic [31:0] s;
        s = 32'(win >> {ln, 3'b000});
        case (f3[1:0])
            2'b00:   extract = {{24{s[7] & ~f3[2]}}, s[7:0]};
            2'b01:   extract = {{16{s[15] & ~f3[2]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

    always_comb begin
        lane  = req_addr[1:0];
        widx  = {1'b0, req_addr[ADDR_W-1:2]};
        widx1 = widx + 1'b1;
        idx   = widx[IW-1:0];
        idx1  = widx1[IW-1:0];
        case (req_funct3[1:0])
            2'b00:   begin size = 4'd1; mask = 8'h01; end
            2'b01:   begin size = 4'd2; mask = 8'h03; end
            default: begin size = 4'd4; mask = 8'h0F; end
        endcase
        be8        = mask << lane;
        wd64       = {32'b0, req_wdata} << {lane, 3'b000};
        fmt_ok     = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) &&
                     !(req_we && req_funct3[2]);
        misaligned = ((size == 4'd2) && lane[0]) || ((size == 4'd4) && (lane != 2'b00));
        crosses    = ({2'b00, lane} + size) > 4'd4;
        range_err  = (widx >= DEPTH_X) || (crosses && (widx1 >= DEPTH_X));
        misal_err  = misaligned && !MISALIGN_EN;
        // a split that is out of range still takes both phases so its error keeps the 2-cycle latency
        split_go   = MISALIGN_EN && crosses && fmt_ok;
        req_err    = !fmt_ok || misal_err || range_err;
    end

    assign accept = req_valid && req_ready && !rst;
    assign acc_wr = accept && req_we && !req_err;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && split_go) state_nxt = SPLIT;
            SPLIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        ph2_wr    = (state == SPLIT) && sp_we && !sp_err && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (accept && !split_go) begin
                rsp_valid <= 1'b1;
                rsp_err   <= req_err;
                if (!req_err && !req_we)
                    rsp_rdata <= extract({32'b0, mem[idx]}, lane, req_funct3);
            end
            if (state == SPLIT) begin
                rsp_valid <= 1'b1;
                rsp_err   <= sp_err;
                if (!sp_err && !sp_we)
                    rsp_rdata <= extract({mem[sp_idx], sp_lo}, sp_lane, sp_f3);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && split_go) begin
            sp_idx  <= idx1;
            sp_be   <= be8[7:4];
            sp_wd   <= wd64[63:32];
            sp_we   <= req_we;
            sp_err  <= range_err;
            sp_lo   <= mem[idx];
            sp_lane <= lane;
            sp_f3   <= req_funct3;
        end
    end

    // memory is deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (acc_wr && be8[b])
                mem[idx][8*b +: 8] <= wd64[8*b +: 8];
            if (ph2_wr && sp_be[b])
                mem[sp_idx][8*b +: 8] <= sp_wd[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_be.sv
// Directed self-checking bench for data_memory_be; misaligned cases follow DMEM_MISALIGN_EN.
module tb_data_memory_be;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_be #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        checks++; if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL reset_state got rdy=%b v=%b e=%b d=%h want rdy=1 v=0 e=0 d=0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
        rst = 1'b0; req_valid = 1'b0;
        send(1'b1, F_W, 32'h40, 32'h12345678);
        idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL sw_40 got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL req_in_reset got v=%b want v=0", rsp_valid); end
        rst = 1'b0; req_valid = 1'b0;
        send(1'b0, F_W, 32'h40, 32'h0);
        idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin errors++; $display("FAIL lw_after_reset got v=%b e=%b d=%h want v=1 e=0 d=12345678", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    task automatic test_word();
        send(1'b1, F_W, 32'h10, 32'hA1B2C3D4);
        send(1'b0, F_W, 32'h10, 32'h0);
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL sw_word got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid, rsp_err, rsp_rdata); end
        idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hA1B2C3D4}) begin errors++; $display("FAIL lw_word got v=%b e=%b d=%h want v=1 e=0 d=a1b2c3d4", rsp_valid, rsp_err, rsp_rdata); end
        idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse got v=%b want v=0", rsp_valid); end
    endtask

    task automatic test_byte_half();
        send(1'b1, F_W, 32'h10, 32'h0); idle();
        send(1'b1, F_B, 32'h11, 32'h000000FF); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL sb_11 got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_B, 32'h11, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFFFFFF}) begin errors++; $display("FAIL lb_11 got v=%b e=%b d=%h want v=1 e=0 d=ffffffff", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_BU, 32'h11, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h000000FF}) begin errors++; $display("FAIL lbu_11 got v=%b e=%b d=%h want v=1 e=0 d=000000ff", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h10, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000FF00}) begin errors++; $display("FAIL lw_after_sb got v=%b e=%b d=%h want v=1 e=0 d=0000ff00", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b1, F_H, 32'h12, 32'hFFFF8001); idle();
        send(1'b0, F_H, 32'h12, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFF8001}) begin errors++; $display("FAIL lh_12 got v=%b e=%b d=%h want v=1 e=0 d=ffff8001", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_HU, 32'h12, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h00008001}) begin errors++; $display("FAIL lhu_12 got v=%b e=%b d=%h want v=1 e=0 d=00008001", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h10, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h8001FF00}) begin errors++; $display("FAIL lw_after_sh got v=%b e=%b d=%h want v=1 e=0 d=8001ff00", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    task automatic test_errors();
        send(1'b0, F_W, 32'h400, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL lw_oob got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, 3'b011, 32'h10, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL ld_f3_011 got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b1, F_HU, 32'h10, 32'h00001111); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL st_f3_101 got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b1, F_BU, 32'h10, 32'h00000022); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL st_f3_100 got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h10, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h8001FF00}) begin errors++; $display("FAIL mem_after_err got v=%b e=%b d=%h want v=1 e=0 d=8001ff00", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b1, F_W, 32'h3FC, 32'hCAFEF00D); idle();
        send(1'b0, F_W, 32'h3FC, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL lw_last_word got v=%b e=%b d=%h want v=1 e=0 d=cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    task automatic test_misalign();
        send(1'b1, F_W, 32'h20, 32'h44332211); idle();
        send(1'b1, F_W, 32'h24, 32'h88776655); idle();
        send(1'b0, F_W, 32'h23, 32'h0);
        idle();
`ifdef DMEM_MISALIGN_EN
        checks++; if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL split_ph1 got rdy=%b v=%b want rdy=0 v=0", req_ready, rsp_valid); end
        idle();
        checks++; if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h77665544}) begin errors++; $display("FAIL lw_23_split got rdy=%b v=%b e=%b d=%h want rdy=1 v=1 e=0 d=77665544", req_ready, rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_H, 32'h21, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h00003322}) begin errors++; $display("FAIL lh_21 got v=%b e=%b d=%h want v=1 e=0 d=00003322", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h3FD, 32'h0); idle(); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL split_oob got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
`else
        checks++; if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL lw_23_err got rdy=%b v=%b e=%b d=%h want rdy=1 v=1 e=1 d=0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_H, 32'h21, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL lh_21_err got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b1, F_W, 32'h22, 32'hFFFFFFFF); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL sw_22_err got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h20, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h44332211}) begin errors++; $display("FAIL lw_20_kept got v=%b e=%b d=%h want v=1 e=0 d=44332211", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h24, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h88776655}) begin errors++; $display("FAIL lw_24_kept got v=%b e=%b d=%h want v=1 e=0 d=88776655", rsp_valid, rsp_err, rsp_rdata); end
`endif
    endtask

`ifdef DMEM_MISALIGN_EN
    task automatic test_reset_split();
        send(1'b1, F_W, 32'h28, 32'h0BADF00D); idle();
        send(1'b1, F_W, 32'h26, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL sw_26_ph1 got rdy=%b v=%b want rdy=0 v=0", req_ready, rsp_valid); end
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL split_rst got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid); end
        rst = 1'b0;
        idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL split_rst_norsp got v=%b want v=0", rsp_valid); end
        send(1'b0, F_W, 32'h24, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hBEEF6655}) begin errors++; $display("FAIL lw_24_ph1 got v=%b e=%b d=%h want v=1 e=0 d=beef6655", rsp_valid, rsp_err, rsp_rdata); end
        send(1'b0, F_W, 32'h28, 32'h0); idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0BADF00D}) begin errors++; $display("FAIL lw_28_kept got v=%b e=%b d=%h want v=1 e=0 d=0badf00d", rsp_valid, rsp_err, rsp_rdata); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] d, pd;
        pd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            d = 32'hC0DE0000 + (i / 2) * 32'h1111;
            send((i % 2) == 0, F_W, 32'h80 + (i / 2) * 4, d);
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready op %0d got %b want 1", i, req_ready); end
            if (i > 0) begin
                checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, ((i % 2) == 1) ? 32'h0 : pd}) begin errors++; $display("FAIL b2b_rsp op %0d got v=%b e=%b d=%h want v=1 e=0 d=%h", i - 1, rsp_valid, rsp_err, rsp_rdata, ((i % 2) == 1) ? 32'h0 : pd); end
            end
            pd = d;
        end
        idle();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, pd}) begin errors++; $display("FAIL b2b_rsp op 7 got v=%b e=%b d=%h want v=1 e=0 d=%h", rsp_valid, rsp_err, rsp_rdata, pd); end
        idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got v=%b want v=0", rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_misalign();
`ifdef DMEM_MISALIGN_EN
        test_reset_split();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
